// File: rtl/i2c_pattern_sequencer.sv
// i2c_pattern_sequencer
// Watches a raw I2C bus, frames START/STOP/BIT events and checks the transferred
// bytes (each followed by an ACK) against a programmable byte pattern. A complete,
// ACKed pattern followed by STOP gives a one-cycle match pulse; any deviation gives
// a one-cycle mismatch pulse and the sequencer re-arms for the next START.
// Optional build macro: I2C_SEQ_GLITCH_FILTER_EN adds a 3-sample glitch filter on
// both synchronised bus lines (+2 clk latency).
module i2c_pattern_sequencer #(
    parameter int unsigned NBYTES      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sda_in,
    input  logic                  scl_in,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [3:0]            pat_len,
    input  logic [8*NBYTES-1:0]   pat_data,
    output logic                  busy,
    output logic                  match,
    output logic                  mismatch,
    output logic [2:0]            byte_idx,
    output logic [2:0]            state_out
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StArmed    = 3'd1,
        StData     = 3'd2,
        StAck      = 3'd3,
        StWaitStop = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sda_sync_q, scl_sync_q;
    logic                   sda_s, scl_s;
    logic                   sda_c, scl_c, sda_p, scl_p;

    // Synchronisers; reset to 1 so an idle (high) bus produces no events.
    always_ff @(posedge clk) begin
        if (reset) begin
            sda_sync_q <= '1;
            scl_sync_q <= '1;
        end else begin
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        end
    end

    assign sda_s = sda_sync_q[SYNC_STAGES-1];
    assign scl_s = scl_sync_q[SYNC_STAGES-1];

`ifdef I2C_SEQ_GLITCH_FILTER_EN
    logic [1:0] sda_hist_q, scl_hist_q;
    logic       sda_filt_q, scl_filt_q;

    // Filtered value follows the line only once three consecutive samples agree.
    always_comb begin
        sda_c = sda_filt_q;
        scl_c = scl_filt_q;
        if ((sda_s == sda_hist_q[0]) && (sda_hist_q[0] == sda_hist_q[1])) sda_c = sda_s;
        if ((scl_s == scl_hist_q[0]) && (scl_hist_q[0] == scl_hist_q[1])) scl_c = scl_s;
    end

    // Sample history and filtered previous-sample registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sda_hist_q <= '1;
            scl_hist_q <= '1;
            sda_filt_q <= 1'b1;
            scl_filt_q <= 1'b1;
        end else begin
            sda_hist_q <= {sda_hist_q[0], sda_s};
            scl_hist_q <= {scl_hist_q[0], scl_s};
            sda_filt_q <= sda_c;
            scl_filt_q <= scl_c;
        end
    end

    assign sda_p = sda_filt_q;
    assign scl_p = scl_filt_q;
`else
    logic sda_prev_q, scl_prev_q;

    // Previous synchronised sample for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sda_prev_q <= 1'b1;
            scl_prev_q <= 1'b1;
        end else begin
            sda_prev_q <= sda_s;
            scl_prev_q <= scl_s;
        end
    end

    assign sda_c = sda_s;
    assign scl_c = scl_s;
    assign sda_p = sda_prev_q;
    assign scl_p = scl_prev_q;
`endif

    // Bus events; a simultaneous scl/sda change only ever yields the scl edge.
    logic ev_start, ev_stop, ev_bit;
    assign ev_start = scl_p & scl_c & sda_p & ~sda_c;
    assign ev_stop  = scl_p & scl_c & ~sda_p & sda_c;
    assign ev_bit   = ~scl_p & scl_c;

    state_t                state_q;
    logic [8*NBYTES-1:0]   pat_q;
    logic [3:0]            len_q;
    logic [7:0]            shift_q;
    logic [2:0]            bit_cnt_q;
    logic [2:0]            byte_idx_q;
    logic                  match_q, mismatch_q;
    logic [7:0]            shifted;
    logic [7:0]            cur_byte;
    logic [3:0]            len_clamped;
    logic                  last_byte;

    // Pattern byte selected by the current byte index.
    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            if (byte_idx_q == 3'(i)) cur_byte = pat_q[8*i +: 8];
        end
    end

    assign shifted     = {shift_q[6:0], sda_c};
    assign len_clamped = (pat_len > 4'(NBYTES)) ? 4'(NBYTES) : pat_len;
    assign last_byte   = ({1'b0, byte_idx_q} == (len_q - 4'd1));

    // Sequencer FSM with registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pat_q      <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            if (abort) begin
                state_q    <= StIdle;
                bit_cnt_q  <= '0;
                byte_idx_q <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (arm && (pat_len != 4'd0)) begin
                            pat_q      <= pat_data;
                            len_q      <= len_clamped;
                            bit_cnt_q  <= '0;
                            byte_idx_q <= '0;
                            state_q    <= StArmed;
                        end
                    end
                    StArmed: begin
                        if (ev_start) begin
                            bit_cnt_q  <= '0;
                            byte_idx_q <= '0;
                            state_q    <= StData;
                        end
                    end
                    StData, StAck, StWaitStop: begin
                        if (ev_start) begin
                            // Repeated start: report the failure, hunt again at once.
                            mismatch_q <= 1'b1;
                            bit_cnt_q  <= '0;
                            byte_idx_q <= '0;
                            state_q    <= StData;
                        end else if (ev_stop) begin
                            if (state_q == StWaitStop) begin
                                match_q <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                mismatch_q <= 1'b1;
                                state_q    <= StArmed;
                            end
                            bit_cnt_q  <= '0;
                            byte_idx_q <= '0;
                        end else if (ev_bit) begin
                            if (state_q == StData) begin
                                shift_q   <= shifted;
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'd7) begin
                                    if (shifted == cur_byte) begin
                                        state_q <= StAck;
                                    end else begin
                                        mismatch_q <= 1'b1;
                                        bit_cnt_q  <= '0;
                                        byte_idx_q <= '0;
                                        state_q    <= StArmed;
                                    end
                                end
                            end else if ((state_q == StAck) && !sda_c) begin
                                bit_cnt_q <= '0;
                                if (last_byte) begin
                                    state_q <= StWaitStop;
                                end else begin
                                    byte_idx_q <= byte_idx_q + 3'd1;
                                    state_q    <= StData;
                                end
                            end else begin
                                // NACK, or any clocked bit while waiting for STOP.
                                mismatch_q <= 1'b1;
                                bit_cnt_q  <= '0;
                                byte_idx_q <= '0;
                                state_q    <= StArmed;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign match     = match_q;
    assign mismatch  = mismatch_q;
    assign byte_idx  = byte_idx_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_i2c_pattern_sequencer.sv
// Testbench for i2c_pattern_sequencer: table-driven transfers plus hand-written
// sequences for latency, reset, abort, repeated start and scl glitch behaviour.
module tb_i2c_pattern_sequencer;

    localparam int SYNC = 2;
`ifdef I2C_SEQ_GLITCH_FILTER_EN
    localparam int LAT = SYNC + 2;
`else
    localparam int LAT = SYNC;
`endif

    logic        clk = 1'b0;
    logic        reset, sda, scl, arm, abort;
    logic [3:0]  pat_len;
    logic [31:0] pat_data;
    logic        busy, match, mismatch;
    logic [2:0]  byte_idx, state_out;

    int n_pass = 0;
    int n_total = 0;
    int match_cnt = 0, mis_cnt = 0, both_cnt = 0, wide_cnt = 0;
    logic match_prev = 1'b0, mis_prev = 1'b0;

    i2c_pattern_sequencer #(.NBYTES(4), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .reset    (reset),
        .sda_in   (sda),
        .scl_in   (scl),
        .arm      (arm),
        .abort    (abort),
        .pat_len  (pat_len),
        .pat_data (pat_data),
        .busy     (busy),
        .match    (match),
        .mismatch (mismatch),
        .byte_idx (byte_idx),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (match) match_cnt <= match_cnt + 1;
        if (mismatch) mis_cnt <= mis_cnt + 1;
        if (match && mismatch) both_cnt <= both_cnt + 1;
        if ((match && match_prev) || (mismatch && mis_prev)) wide_cnt <= wide_cnt + 1;
        match_prev <= match;
        mis_prev   <= mismatch;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] pat;
        logic [3:0]  len;
        int          nsend;
        logic [31:0] data;
        logic [3:0]  acks;
        int          exp_match;
        int          exp_mis;
        int          exp_state;
        int          exp_idx;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda = b;  wait_n(2);
        scl = 1'b1; wait_n(4);
        scl = 1'b0; wait_n(2);
    endtask

    // Data bit with a 1-clk low glitch in the middle of its high phase.
    task automatic send_bit_glitch(input logic b);
        sda = b;  wait_n(2);
        scl = 1'b1; wait_n(2);
        scl = 1'b0; wait_n(1);
        scl = 1'b1; wait_n(2);
        scl = 1'b0; wait_n(2);
    endtask

    task automatic send_data(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic i2c_start;
        sda = 1'b1; wait_n(2);
        scl = 1'b1; wait_n(4);
        sda = 1'b0; wait_n(4);
        scl = 1'b0; wait_n(2);
    endtask

    task automatic i2c_stop;
        sda = 1'b0; wait_n(2);
        scl = 1'b1; wait_n(4);
        sda = 1'b1; wait_n(4);
    endtask

    // Final ACK clocked, then STOP while scl is still high.
    task automatic ack_stop(input logic ack);
        if (!ack) begin
            sda = 1'b0; wait_n(2);
            scl = 1'b1; wait_n(4);
            sda = 1'b1; wait_n(4);
        end else begin
            send_bit(1'b1);
            i2c_stop();
        end
    endtask

    task automatic do_abort;
        abort = 1'b1; wait_n(1);
        abort = 1'b0; wait_n(2);
    endtask

    task automatic do_arm(input logic [31:0] p, input logic [3:0] l);
        pat_data = p;
        pat_len  = l;
        arm = 1'b1; wait_n(1);
        arm = 1'b0; wait_n(1);
    endtask

    task automatic run_vec(input int i);
        int m0, x0;
        string tag;
        tag = $sformatf("vec%0d", i);
        do_abort();
        do_arm(vecs[i].pat, vecs[i].len);
        m0 = match_cnt;
        x0 = mis_cnt;
        i2c_start();
        for (int b = 0; b < vecs[i].nsend; b++) begin
            send_data(vecs[i].data[8*b +: 8]);
            if (b == vecs[i].nsend - 1) ack_stop(vecs[i].acks[b]);
            else send_bit(vecs[i].acks[b]);
        end
        wait_n(10);
        chk({tag, "_match"}, match_cnt - m0, vecs[i].exp_match);
        chk({tag, "_mismatch"}, mis_cnt - x0, vecs[i].exp_mis);
        chk({tag, "_state"}, int'(state_out), vecs[i].exp_state);
        chk({tag, "_byte_idx"}, int'(byte_idx), vecs[i].exp_idx);
        chk({tag, "_busy"}, int'(busy), (vecs[i].exp_state != 0) ? 1 : 0);
    endtask

    initial begin
        int m0, x0;
        //          pat           len  n  data          acks     m  x  st idx
        vecs[0] = '{32'h0000_5CA6, 4'd2,  2, 32'h0000_5CA6, 4'b0000, 1, 0, 0, 0};
        vecs[1] = '{32'h0000_5CA6, 4'd2,  2, 32'h0000_5DA6, 4'b0000, 0, 1, 1, 0};
        vecs[2] = '{32'h0000_5CA6, 4'd2,  1, 32'h0000_00A6, 4'b0001, 0, 1, 1, 0};
        vecs[3] = '{32'h0000_003C, 4'd1,  1, 32'h0000_003C, 4'b0000, 1, 0, 0, 0};
        vecs[4] = '{32'h4433_2211, 4'd15, 4, 32'h4433_2211, 4'b0000, 1, 0, 0, 0};
        vecs[5] = '{32'h0000_5CA6, 4'd2,  3, 32'h0077_5CA6, 4'b0000, 0, 1, 1, 0};
        vecs[6] = '{32'h0000_5CA6, 4'd2,  1, 32'h0000_00A6, 4'b0000, 0, 1, 1, 0};
        vecs[7] = '{32'h0000_5CA6, 4'd0,  2, 32'h0000_5CA6, 4'b0000, 0, 0, 0, 0};
        vecs[8] = '{32'h0000_5CA6, 4'd2,  1, 32'h0000_0000, 4'b0000, 0, 1, 1, 0};
        vecs[9] = '{32'h0033_2211, 4'd3,  3, 32'h0033_2211, 4'b0010, 0, 1, 1, 0};

        reset = 1'b1; sda = 1'b1; scl = 1'b1; arm = 1'b0; abort = 1'b0;
        pat_len = '0; pat_data = '0;
        wait_n(3);
        chk("reset_state", int'(state_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_match", int'(match), 0);
        chk("reset_mismatch", int'(mismatch), 0);
        chk("reset_byte_idx", int'(byte_idx), 0);
        reset = 1'b0;
        wait_n(4);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Match latency and width, measured from the edge that samples STOP.
        do_abort();
        do_arm(32'h5CA6, 4'd2);
        i2c_start();
        send_data(8'hA6); send_bit(1'b0);
        send_data(8'h5C);
        sda = 1'b0; wait_n(2);
        scl = 1'b1; wait_n(4);
        sda = 1'b1;
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1 chk("lat_match_early", int'(match), 0);
        @(posedge clk);
        #1 chk("lat_match_high", int'(match), 1);
        chk("lat_state_idle", int'(state_out), 0);
        chk("lat_busy", int'(busy), 0);
        @(posedge clk);
        #1 chk("lat_match_low", int'(match), 0);
        wait_n(6);

        // STOP after first byte, then a full correct transfer.
        do_abort();
        do_arm(32'h5CA6, 4'd2);
        m0 = match_cnt; x0 = mis_cnt;
        i2c_start();
        send_data(8'hA6); ack_stop(1'b0);
        wait_n(8);
        chk("early_stop_mismatch", mis_cnt - x0, 1);
        chk("early_stop_match", match_cnt - m0, 0);
        chk("early_stop_state", int'(state_out), 1);
        i2c_start();
        send_data(8'hA6); send_bit(1'b0);
        send_data(8'h5C); ack_stop(1'b0);
        wait_n(8);
        chk("rearm_match", match_cnt - m0, 1);
        chk("rearm_mismatch", mis_cnt - x0, 1);
        chk("rearm_state", int'(state_out), 0);

        // Repeated start after byte 0.
        do_abort();
        do_arm(32'h5CA6, 4'd2);
        m0 = match_cnt; x0 = mis_cnt;
        i2c_start();
        send_data(8'hA6); send_bit(1'b0);
        chk("rs_pre_state", int'(state_out), 2);
        chk("rs_pre_idx", int'(byte_idx), 1);
        i2c_start();
        wait_n(4);
        chk("rs_mismatch", mis_cnt - x0, 1);
        chk("rs_state", int'(state_out), 2);
        chk("rs_idx", int'(byte_idx), 0);
        send_data(8'hA6); send_bit(1'b0);
        send_data(8'h5C); ack_stop(1'b0);
        wait_n(8);
        chk("rs_match", match_cnt - m0, 1);
        chk("rs_final_state", int'(state_out), 0);

        // Abort mid-transfer: back to idle with no pulse.
        do_abort();
        do_arm(32'h5CA6, 4'd2);
        m0 = match_cnt; x0 = mis_cnt;
        i2c_start();
        send_data(8'hA6); send_bit(1'b0);
        do_abort();
        chk("abort_state", int'(state_out), 0);
        chk("abort_idx", int'(byte_idx), 0);
        send_data(8'h5C); ack_stop(1'b0);
        wait_n(8);
        chk("abort_pulses", (match_cnt - m0) + (mis_cnt - x0), 0);

        // Reset mid-byte; a later START without arm must be ignored.
        do_abort();
        do_arm(32'h5CA6, 4'd2);
        m0 = match_cnt; x0 = mis_cnt;
        i2c_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1 chk("midreset_state", int'(state_out), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_idx", int'(byte_idx), 0);
        chk("midreset_pulse", int'(match) + int'(mismatch), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        i2c_start();
        send_data(8'hA6); send_bit(1'b0);
        chk("noarm_state", int'(state_out), 0);
        send_data(8'h5C); ack_stop(1'b0);
        wait_n(8);
        chk("noarm_pulses", (match_cnt - m0) + (mis_cnt - x0), 0);

        // 1-clk low glitch on scl during the first data bit.
        do_abort();
        do_arm(32'h5CA6, 4'd2);
        m0 = match_cnt; x0 = mis_cnt;
        i2c_start();
        send_bit_glitch(1'b1);
        for (int i = 6; i >= 0; i--) send_bit(logic'((8'hA6 >> i) & 8'h1));
        send_bit(1'b0);
        send_data(8'h5C); ack_stop(1'b0);
        wait_n(8);
`ifdef I2C_SEQ_GLITCH_FILTER_EN
        chk("glitch_match", match_cnt - m0, 1);
        chk("glitch_mismatch", mis_cnt - x0, 0);
        chk("glitch_state", int'(state_out), 0);
`else
        chk("glitch_match", match_cnt - m0, 0);
        chk("glitch_mismatch", mis_cnt - x0, 1);
        chk("glitch_state", int'(state_out), 1);
`endif

        wait_n(2);
        chk("pulses_never_both", both_cnt, 0);
        chk("pulses_one_clk", wide_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
